// File: rtl/cpu_pkg.sv
// Shared core types for the decode-stage register file.
package cpu_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: issue increments, retiring writes and
// kills decrement. Produces rd_busy for each read port and issue_ready for ID.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int NKILL    = 2,
    parameter int PEND_MAX = 3,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(PEND_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD-1:0][AW-1:0]    rd_addr,
    output logic [NRD-1:0]            rd_busy,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR-1:0][AW-1:0]    wr_addr,
    input  logic [NWR-1:0]            wr_sb_clr,
    input  logic                      issue_en,
    input  logic [AW-1:0]             issue_rd,
    output logic                      issue_ready,
    input  logic [NKILL-1:0]          kill_en,
    input  logic [NKILL-1:0][AW-1:0]  kill_rd
);
    logic [NREGS-1:0][CW-1:0] cnt_q;
    logic [NREGS-1:0][CW-1:0] cnt_nxt;
    logic [NREGS-1:0]         unf;
    logic [NREGS-1:0]         ovf;
    int                       dsum;
    int                       bsum;

    // Next count per register: +issue, -retiring clears, -kills, saturating both ways.
    always_comb begin
        cnt_nxt = '0;
        unf     = '0;
        ovf     = '0;
        dsum    = 0;
        for (int r = 1; r < NREGS; r++) begin
            dsum = int'(cnt_q[r]);
            if (issue_en && issue_rd == AW'(r)) begin
                dsum++;
                ovf[r] = (cnt_q[r] == CW'(PEND_MAX));
            end
            for (int i = 0; i < NWR; i++)
                if (wr_en[i] && wr_sb_clr[i] && wr_addr[i] == AW'(r)) dsum--;
            for (int k = 0; k < NKILL; k++)
                if (kill_en[k] && kill_rd[k] == AW'(r)) dsum--;
            if (dsum < 0) begin
                unf[r]     = 1'b1;
                cnt_nxt[r] = '0;
            end else if (dsum > PEND_MAX) begin
                cnt_nxt[r] = CW'(PEND_MAX);
            end else begin
                cnt_nxt[r] = CW'(dsum);
            end
        end
    end

    // Counter array; x0 is never written so it stays at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_nxt;
    end

    // Busy = outstanding count minus this cycle's retiring writes; issue and kill are ignored.
    always_comb begin
        rd_busy = '0;
        bsum    = 0;
        for (int p = 0; p < NRD; p++) begin
            bsum = int'(cnt_q[rd_addr[p]]);
            for (int i = 0; i < NWR; i++)
                if (wr_en[i] && wr_sb_clr[i] && wr_addr[i] == rd_addr[p]) bsum--;
            rd_busy[p] = (rd_addr[p] != '0) && (bsum > 0);
        end
    end

    assign issue_ready = (issue_rd == '0) || (cnt_q[issue_rd] < CW'(PEND_MAX));

    // ID must honour issue_ready and never retire/kill more than was issued.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) unf == '0);
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) ovf == '0);
endmodule

// File: rtl/regfile_sb.sv
// Decode-stage integer register file with same-cycle write-back bypass and a
// pending-write scoreboard. Define REGFILE_RESET_EN to clear the array on rst;
// leave it undefined for a reset-less array that maps onto RAM primitives.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int NKILL    = 2,
    parameter int PEND_MAX = 3,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD-1:0][AW-1:0]    rd_addr,
    output logic [NRD-1:0][XLEN-1:0]  rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR-1:0][AW-1:0]    wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data,
    input  logic [NWR-1:0]            wr_sb_clr,
    input  logic                      issue_en,
    input  logic [AW-1:0]             issue_rd,
    output logic                      issue_ready,
    input  logic [NKILL-1:0]          kill_en,
    input  logic [NKILL-1:0][AW-1:0]  kill_rd
);
    logic [XLEN-1:0] mem [NREGS];

`ifdef REGFILE_RESET_EN
    // Array write, cleared on reset; later ports overwrite earlier ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++)
                if (wr_en[i] && wr_addr[i] != '0) mem[wr_addr[i]] <= wr_data[i];
        end
    end
`else
    // Array write without reset; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NWR; i++)
                if (wr_en[i] && wr_addr[i] != '0) mem[wr_addr[i]] <= wr_data[i];
        end
    end
`endif

    // Read mux: array value, overridden by the highest matching write port, x0 forced to 0.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data[p] = mem[rd_addr[p]];
            for (int i = 0; i < NWR; i++)
                if (wr_en[i] && wr_addr[i] == rd_addr[p]) rd_data[p] = wr_data[i];
            if (rd_addr[p] == '0) rd_data[p] = '0;
        end
    end

    rf_scoreboard #(
        .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .NKILL(NKILL), .PEND_MAX(PEND_MAX)
    ) u_sb (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_sb_clr(wr_sb_clr),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .kill_en(kill_en), .kill_rd(kill_rd)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb with two write ports: directed scenarios, then random
// traffic checked against an array/counter reference model.
module tb_regfile_sb;
    import cpu_pkg::*;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, NKILL = 2, PEND_MAX = 3;
    localparam int AW = $clog2(NREGS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NRD-1:0]            rd_busy;
    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic [NWR-1:0]            wr_sb_clr;
    logic                      issue_en;
    logic [AW-1:0]             issue_rd;
    logic                      issue_ready;
    logic [NKILL-1:0]          kill_en;
    logic [NKILL-1:0][AW-1:0]  kill_rd;

    int checks = 0;
    int failures = 0;

    xword_t m_mem [NREGS];
    bit     m_known [NREGS];
    int     m_cnt [NREGS];

    regfile_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .NKILL(NKILL), .PEND_MAX(PEND_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sb_clr(wr_sb_clr),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .kill_en(kill_en), .kill_rd(kill_rd)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_sb_clr = '0;
        issue_en = 1'b0; issue_rd = '0; kill_en = '0; kill_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd_addr[0] = AW'(3); rd_addr[1] = AW'(0); issue_rd = AW'(3);
        tick(); tick();
        #2;
        checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", rd_busy); end
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 2'b01; wr_addr[0] = AW'(5); wr_data[0] = 32'hDEADBEEF;
        rd_addr[0] = AW'(1); rd_addr[1] = AW'(2);
        tick();
        idle(); rd_addr[0] = AW'(5); rd_addr[1] = AW'(5);
        #2;
        checks++; if (rd_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_p0 got=%h exp=deadbeef", rd_data[0]); end
        checks++; if (rd_data[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_p1 got=%h exp=deadbeef", rd_data[1]); end
        wr_en = 2'b01; wr_addr[0] = AW'(0); wr_data[0] = 32'h1234;
        rd_addr[0] = AW'(0); rd_addr[1] = AW'(0);
        #2;
        checks++; if (rd_data[0] !== 32'h0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", rd_data[0]); end
        tick();
        idle();
        #2;
        checks++; if (rd_data[1] !== 32'h0) begin failures++; $display("FAIL x0_read got=%h exp=0", rd_data[1]); end
        checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL x0_busy got=%b exp=00", rd_busy); end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 2'b01; wr_addr[0] = AW'(7); wr_data[0] = 32'hA5A5A5A5;
        rd_addr[0] = AW'(7); rd_addr[1] = AW'(7);
        #2;
        checks++; if (rd_data[0] !== 32'hA5A5A5A5) begin failures++; $display("FAIL bypass got=%h exp=a5a5a5a5", rd_data[0]); end
        tick();
        wr_en = 2'b11; wr_addr[0] = AW'(7); wr_addr[1] = AW'(7);
        wr_data[0] = 32'h1; wr_data[1] = 32'h2;
        #2;
        checks++; if (rd_data[1] !== 32'h2) begin failures++; $display("FAIL bypass_prio got=%h exp=2", rd_data[1]); end
        tick();
        idle();
        #2;
        checks++; if (rd_data[0] !== 32'h2) begin failures++; $display("FAIL write_prio got=%h exp=2", rd_data[0]); end
    endtask

    task automatic test_pending();
        idle();
        issue_en = 1'b1; issue_rd = AW'(3); rd_addr[0] = AW'(3);
        #2;
        checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL issue_same_cycle got=%b exp=0", rd_busy[0]); end
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL ready_cnt0 got=%b exp=1", issue_ready); end
        tick(); tick(); tick();
        idle(); issue_rd = AW'(3);
        #2;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL ready_full got=%b exp=0", issue_ready); end
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL busy_full got=%b exp=1", rd_busy[0]); end
        wr_en = 2'b01; wr_addr[0] = AW'(3); wr_sb_clr = 2'b01; wr_data[0] = 32'h33;
        #2;
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL busy_retire3 got=%b exp=1", rd_busy[0]); end
        tick();
        idle(); issue_rd = AW'(3);
        #2;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL ready_after_retire got=%b exp=1", issue_ready); end
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL busy_after_retire got=%b exp=1", rd_busy[0]); end
    endtask

    task automatic test_retire_bypass();
        idle();
        issue_en = 1'b1; issue_rd = AW'(9);
        tick();
        idle(); rd_addr[0] = AW'(9);
        #2;
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL busy_x9 got=%b exp=1", rd_busy[0]); end
        wr_en = 2'b01; wr_addr[0] = AW'(9); wr_sb_clr = 2'b01; wr_data[0] = 32'h99990001;
        #2;
        checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL busy_retire_x9 got=%b exp=0", rd_busy[0]); end
        checks++; if (rd_data[0] !== 32'h99990001) begin failures++; $display("FAIL data_retire_x9 got=%h exp=99990001", rd_data[0]); end
        tick();
        idle();
        #2;
        checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL busy_x9_after got=%b exp=0", rd_busy[0]); end
    endtask

    task automatic test_kill();
        idle();
        issue_en = 1'b1; issue_rd = AW'(4);
        tick(); tick();
        idle(); rd_addr[0] = AW'(4);
        #2;
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL busy_x4 got=%b exp=1", rd_busy[0]); end
        kill_en = 2'b11; kill_rd[0] = AW'(4); kill_rd[1] = AW'(4);
        #2;
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL busy_kill_cycle got=%b exp=1", rd_busy[0]); end
        tick();
        idle(); issue_rd = AW'(4);
        #2;
        checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL busy_after_kill got=%b exp=0", rd_busy[0]); end
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL ready_after_kill got=%b exp=1", issue_ready); end
    endtask

    task automatic test_reset_mid();
        logic [XLEN-1:0] exp10;
`ifdef REGFILE_RESET_EN
        exp10 = 32'h0;
`else
        exp10 = 32'h55;
`endif
        idle();
        wr_en = 2'b01; wr_addr[0] = AW'(10); wr_data[0] = 32'h55;
        issue_en = 1'b1; issue_rd = AW'(11);
        tick(); tick(); tick();
        idle(); rd_addr[0] = AW'(11); rd_addr[1] = AW'(10); issue_rd = AW'(11);
        #2;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL pre_rst_ready got=%b exp=0", issue_ready); end
        checks++; if (rd_data[1] !== 32'h55) begin failures++; $display("FAIL pre_rst_x10 got=%h exp=55", rd_data[1]); end
        rst = 1'b1;
        #1;
        checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL rst_busy got=%b exp=00", rd_busy); end
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", issue_ready); end
        checks++; if (rd_data[1] !== exp10) begin failures++; $display("FAIL rst_x10 got=%h exp=%h", rd_data[1], exp10); end
        wr_en = 2'b01; wr_addr[0] = AW'(12); wr_data[0] = 32'h77;
        tick();
        rst = 1'b0;
        idle(); rd_addr[1] = AW'(12);
        #2;
        checks++; if (rd_data[1] === 32'h77) begin failures++; $display("FAIL rst_edge_write got=%h exp=not 77", rd_data[1]); end
        tick();
        for (int r = 0; r < NREGS; r++) begin
            m_cnt[r] = 0;
            m_mem[r] = '0;
`ifdef REGFILE_RESET_EN
            m_known[r] = 1'b1;
`else
            m_known[r] = (r == 0);
`endif
        end
    endtask

    task automatic test_random();
        int avail [NREGS];
        int a, eb_cnt;
        bit have, eb, er;
        logic [XLEN-1:0] ed;
        for (int c = 0; c < 400; c++) begin
            avail = m_cnt;
            idle();
            for (int i = 0; i < NWR; i++) begin
                wr_en[i]   = ($urandom_range(0, 3) != 0);
                wr_addr[i] = AW'($urandom_range(0, 7));
                wr_data[i] = $urandom;
                if (wr_en[i]) begin
                    if ($urandom_range(0, 1) == 1 && avail[wr_addr[i]] > 0) begin
                        wr_sb_clr[i] = 1'b1;
                        avail[wr_addr[i]]--;
                    end
                end else begin
                    wr_sb_clr[i] = ($urandom_range(0, 1) == 1);
                end
            end
            for (int k = 0; k < NKILL; k++) begin
                kill_rd[k] = AW'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0 && avail[kill_rd[k]] > 0) begin
                    kill_en[k] = 1'b1;
                    avail[kill_rd[k]]--;
                end
            end
            issue_rd = AW'($urandom_range(0, 7));
            issue_en = ($urandom_range(0, 1) == 1) && (issue_rd == '0 || m_cnt[issue_rd] < PEND_MAX);
            for (int p = 0; p < NRD; p++) rd_addr[p] = AW'($urandom_range(0, 7));
            #2;
            for (int p = 0; p < NRD; p++) begin
                a = int'(rd_addr[p]);
                ed = m_mem[a];
                have = m_known[a];
                eb_cnt = m_cnt[a];
                for (int i = 0; i < NWR; i++) begin
                    if (wr_en[i] && int'(wr_addr[i]) == a) begin ed = wr_data[i]; have = 1'b1; end
                    if (wr_en[i] && wr_sb_clr[i] && int'(wr_addr[i]) == a) eb_cnt--;
                end
                if (a == 0) begin ed = '0; have = 1'b1; end
                eb = (a != 0) && (eb_cnt > 0);
                if (have) begin
                    checks++; if (rd_data[p] !== ed) begin failures++; $display("FAIL rnd_data c=%0d p=%0d x%0d got=%h exp=%h", c, p, a, rd_data[p], ed); end
                end
                checks++; if (rd_busy[p] !== eb) begin failures++; $display("FAIL rnd_busy c=%0d p=%0d x%0d got=%b exp=%b", c, p, a, rd_busy[p], eb); end
            end
            er = (issue_rd == '0) || (m_cnt[issue_rd] < PEND_MAX);
            checks++; if (issue_ready !== er) begin failures++; $display("FAIL rnd_ready c=%0d x%0d got=%b exp=%b", c, issue_rd, issue_ready, er); end
            @(posedge clk);
            for (int i = 0; i < NWR; i++)
                if (wr_en[i] && wr_addr[i] != '0) begin m_mem[wr_addr[i]] = wr_data[i]; m_known[wr_addr[i]] = 1'b1; end
            m_cnt = avail;
            if (issue_en && issue_rd != '0) m_cnt[issue_rd]++;
            #1;
        end
    endtask

    initial begin
        rd_addr = '0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_pending();
        test_retire_bypass();
        test_kill();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
